// File: rtl/pe_pkg.sv
// pe_pkg: shared PE register-file select encodings and sequencer state type
package pe_pkg;
  localparam int RF_INST_W = 4;
  localparam int R0_SEL = 3;
  localparam int R1_SEL = 2;
  localparam int R2_SEL = 1;
  localparam int R3_SEL = 0;
  localparam logic [RF_INST_W-1:0] RF_SHIFT_ALL = 4'b0000;
  localparam logic [RF_INST_W-1:0] RF_LOAD_ALL = 4'b1111;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/rf_inst_sequencer_table.sv
// rf_seq_table: programmable pattern/repeat table with one write and one asynchronous read port
module rf_seq_table import pe_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH),
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [RF_INST_W-1:0] wsel_i,
  input  logic [CNT_W-1:0]     wrep_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [RF_INST_W-1:0] rsel_o,
  output logic [CNT_W-1:0]     rrep_o
);
  logic [RF_INST_W-1:0] sel_q [DEPTH];
  logic [CNT_W-1:0] rep_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) begin
      sel_q[waddr_i] <= wsel_i;
      rep_q[waddr_i] <= wrep_i;
    end
  end
  assign rsel_o = sel_q[raddr_i];
  assign rrep_o = rep_q[raddr_i];
endmodule

// File: rtl/rf_inst_sequencer.sv
// rf_inst_sequencer: plays table entries as per-cycle register-file select words
module rf_inst_sequencer import pe_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH),
  parameter int CNT_W = 4,
  parameter logic [RF_INST_W-1:0] IDLE_INST = RF_SHIFT_ALL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [RF_INST_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0]     cfg_rep,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic [AW:0]          len,
  input  logic                 abort,
  output logic [RF_INST_W-1:0] reg_file_inst,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        step_idx
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, raddr;
  logic [CNT_W-1:0] rep_q, rep_d, rd_rep;
  logic [AW:0] len_q, len_d, len_cl;
  logic [RF_INST_W-1:0] inst_q, inst_d, rd_sel;
  logic done_q, done_d, err_q, err_d;
  assign len_cl = len > DEPTH_W ? DEPTH_W : len;
  // In IDLE the read port points at entry 0 so the start edge loads it directly
  assign raddr = state_q == RUN ? ptr_q + AW'(1) : '0;
  rf_seq_table #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) u_table (
    .clk(clk),
    .we_i(cfg_we && state_q == IDLE),
    .waddr_i(cfg_addr),
    .wsel_i(cfg_sel),
    .wrep_i(cfg_rep),
    .raddr_i(raddr),
    .rsel_o(rd_sel),
    .rrep_o(rd_rep)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    rep_d = rep_q;
    len_d = len_q;
    inst_d = inst_q;
    done_d = 1'b0;
    err_d = cfg_we && state_q == RUN;
    if (state_q == IDLE) begin
      if (start && len_cl != '0) begin
        state_d = RUN;
        ptr_d = '0;
        len_d = len_cl;
        rep_d = rd_rep;
        inst_d = rd_sel;
      end else done_d = start;
    end else if (abort || (rep_q == '0 && {1'b0, ptr_q} == len_q - (AW+1)'(1))) begin
      state_d = IDLE;
      ptr_d = '0;
      rep_d = '0;
      len_d = '0;
      inst_d = IDLE_INST;
      done_d = 1'b1;
    end else if (rep_q != '0) rep_d = rep_q - CNT_W'(1);
    else begin
      ptr_d = raddr;
      rep_d = rd_rep;
      inst_d = rd_sel;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      rep_q <= '0;
      len_q <= '0;
      inst_q <= IDLE_INST;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rep_q <= rep_d;
      len_q <= len_d;
      inst_q <= inst_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q == RUN;
  assign step_idx = busy ? ptr_q : '0;
  assign reg_file_inst = inst_q;
  assign done = done_q;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_rf_inst_sequencer.sv
// tb_rf_inst_sequencer: randomized scoreboard bench against a table-expansion reference model
module tb_rf_inst_sequencer;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int CNT_W = 4;
  logic clk = 0, rst = 1, cfg_we = 0, start = 0, abort = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [3:0] cfg_sel = '0;
  logic [CNT_W-1:0] cfg_rep = '0;
  logic [AW:0] len = '0;
  logic cfg_err, busy, done;
  logic [3:0] reg_file_inst;
  logic [AW-1:0] step_idx;
  rf_inst_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_rep(cfg_rep), .cfg_err(cfg_err), .start(start), .len(len), .abort(abort),
    .reg_file_inst(reg_file_inst), .busy(busy), .done(done), .step_idx(step_idx)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] sel; int idx;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [3:0] m_sel [DEPTH];
  int m_rep [DEPTH];
  int tests = 0, fails = 0, pend_done = 0, busy_cnt = 0;
  bit err_now = 0, err_next = 0;
  logic [7:0] rd [4], re [4], din [4], din_res;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", n, a, x);
    end
  endtask
  // Monitor: pops the expected word for every busy cycle and checks idle/done/cfg_err behaviour
  always @(negedge clk) begin
    if (!rst) begin
      chk("cfg_err", cfg_err, err_now);
      err_now = err_next;
      err_next = 0;
      if (busy) begin
        busy_cnt++;
        if (exp_q.size() == 0) chk("busy_unexpected", busy, 0);
        else begin
          e = exp_q.pop_front();
          chk("inst", reg_file_inst, e.sel);
          chk("step_idx", step_idx, e.idx);
          foreach (din[k]) din[k] = 8'($urandom);
          din_res = 8'($urandom);
          for (int k = 3; k >= 0; k--) begin
            rd[k] = reg_file_inst[3-k] ? din[k] : (k == 0 ? din_res : rd[k-1]);
            re[k] = e.sel[3-k] ? din[k] : (k == 0 ? din_res : re[k-1]);
          end
        end
      end else begin
        chk("idle_inst", reg_file_inst, 0);
        chk("idle_step", step_idx, 0);
      end
      if (done) begin
        chk("done_expected", pend_done > 0, 1);
        chk("done_queue_empty", exp_q.size(), 0);
        if (pend_done > 0) pend_done--;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input logic [3:0] s, input int r, input bit running);
    cfg_we = 1; cfg_addr = AW'(a); cfg_sel = s; cfg_rep = CNT_W'(r);
    if (running) err_next = 1;
    else begin m_sel[a] = s; m_rep[a] = r; end
    tick;
    cfg_we = 0;
  endtask
  task automatic go(input int l, input bit wr_too = 0, input int a = 0, input logic [3:0] s = 0, input int r = 0);
    int cl = l > DEPTH ? DEPTH : l;
    logic [3:0] s0 = m_sel[0];
    int r0 = m_rep[0];
    start = 1; len = (AW+1)'(l);
    if (wr_too) begin
      cfg_we = 1; cfg_addr = AW'(a); cfg_sel = s; cfg_rep = CNT_W'(r);
      m_sel[a] = s; m_rep[a] = r;
    end
    for (int i = 0; i < cl; i++)
      for (int j = 0; j <= (i == 0 ? r0 : m_rep[i]); j++) exp_q.push_back('{i == 0 ? s0 : m_sel[i], i});
    pend_done++;
    tick;
    start = 0; cfg_we = 0;
  endtask
  function automatic int total(input int l);
    int t = 0;
    for (int i = 0; i < (l > DEPTH ? DEPTH : l); i++) t += m_rep[i] + 1;
    return t;
  endfunction
  task automatic wait_idle;
    int n = 0;
    while ((pend_done > 0 || exp_q.size() > 0) && n < 300) begin tick; n++; end
    chk("timeout", n < 300, 1);
    if (n >= 300) begin exp_q.delete(); pend_done = 0; end
    tick;
  endtask
  initial begin
    int t, l;
    tick; tick;
    chk("rst_inst", reg_file_inst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_err", cfg_err, 0);
    rst = 0;
    for (int a = 0; a < DEPTH; a++) wr(a, 4'($urandom), $urandom_range(0, 3), 0);
    wr(0, 4'b1111, 0, 0); wr(1, 4'b0001, 2, 0); wr(2, 4'b1000, 1, 0);
    foreach (rd[k]) begin rd[k] = 0; re[k] = 0; end
    busy_cnt = 0; go(3); wait_idle;
    chk("basic_busy_cycles", busy_cnt, 6);
    for (int k = 0; k < 4; k++) chk($sformatf("rf_R%0d", k), rd[k], re[k]);
    t = total(9); busy_cnt = 0; go(9); wait_idle;
    chk("clamp_busy_cycles", busy_cnt, t);
    busy_cnt = 0; go(0); wait_idle;
    chk("len0_busy_cycles", busy_cnt, 0);
    wr(0, 4'b0100, 15, 0);
    busy_cnt = 0; go(1);
    repeat (4) tick;
    abort = 1; tick; abort = 0;
    exp_q.delete();
    wait_idle;
    chk("abort_busy_cycles", busy_cnt, 5);
    wr(0, 4'b0011, 3, 0); wr(1, 4'b0101, 3, 0); wr(2, 4'b1001, 3, 0);
    go(3); tick;
    wr(1, 4'b1010, 0, 1);
    start = 1; len = 2; tick; start = 0;
    wait_idle;
    go(3); wait_idle;
    go(3); tick;
    rst = 1; tick; rst = 0;
    exp_q.delete(); pend_done = 0; err_now = 0; err_next = 0;
    repeat (4) tick;
    go(2, 1, 0, 4'b0110, 1); wait_idle;
    go(1); wait_idle;
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, DEPTH-1), 4'($urandom), $urandom_range(0, 4), 0);
      l = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) begin
        abort = 1; tick; abort = 0;
      end
      go(l, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), 4'($urandom), $urandom_range(0, 4));
      wait_idle;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_inst_sequencer.md
Name: rf_inst_sequencer

Overview:
- Sequences the 4-bit per-PE register-file select word (R0..R3 load/shift control, bit3=R0_sel .. bit0=R3_sel) from a small programmable table.
- Each table entry gives a select pattern and a repeat count; on start the block plays entries 0..len-1 back-to-back, then returns to an idle pattern.
- Sits between the PE configuration bus and the register file inside each PE, replacing a static configuration with per-cycle scheduling.

Parameters:
DEPTH, 8, number of table entries (power of two, >=2)
AW, $clog2(DEPTH), table address width
CNT_W, 4, repeat-count width; an entry is applied rep+1 cycles (1..2^CNT_W)
IDLE_INST, 4'b0000, select word driven when not running (pure shift chain: din_res->R0->R1->R2->R3)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cfg_we  input  1  table write strobe
cfg_addr  input  AW  table write address
cfg_sel  input  4  select pattern to store
cfg_rep  input  CNT_W  repeat count to store
cfg_err  output  1  one-cycle pulse: cfg_we arrived while busy, write dropped
start  input  1  launch a sequence (sampled only in IDLE)
len  input  AW+1  number of entries to play, latched at start
abort  input  1  terminate a running sequence
reg_file_inst  output  4  registered select word to the register file
busy  output  1  high in RUN
done  output  1  one-cycle pulse after the last application cycle, or after abort
step_idx  output  AW  index of the entry currently driven (0 in IDLE)

Behaviour:
- Reset: state=IDLE, reg_file_inst=IDLE_INST, busy=0, done=0, cfg_err=0, step_idx=0, internal ptr/rep_cnt/len_q=0. Table contents are not reset (X until written); the bench must write entries before use.
- Table: DEPTH x (4+CNT_W) flops; written on the clk edge when cfg_we=1 and state=IDLE. cfg_we in RUN: no write, cfg_err=1 next cycle.
- States: IDLE, RUN.
- IDLE -> RUN: start=1 and the clamped len is nonzero. len_q=min(len,DEPTH); ptr=0; rep_cnt=table[0].rep; next-cycle reg_file_inst=table[0].sel, busy=1. Latency start->first pattern = 1 cycle.
- start with len=0: stay IDLE, done=1 next cycle, reg_file_inst stays IDLE_INST.
- Simultaneous start and cfg_we in IDLE: the write lands on the same edge, and the sequence reads the pre-write table value (registered read of the old contents on that edge).
- RUN: each cycle, if rep_cnt!=0, decrement rep_cnt and hold the pattern; else if ptr==len_q-1, go IDLE, reg_file_inst=IDLE_INST, busy=0, done=1 (same edge); else ptr++, load table[ptr+1] into the output and rep_cnt.
- Total RUN cycles = sum over played entries of (rep_i+1). No gap cycles between entries.
- start in RUN: ignored.
- abort in RUN (priority over normal stepping): next cycle IDLE, IDLE_INST, busy=0, done=1. abort in IDLE: no effect.
- rst mid-RUN: immediate return to reset values on that edge; no done pulse.
- step_idx = ptr while busy, else 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (pe_pkg): RF_INST_W=4; bit positions R0_SEL=3, R1_SEL=2, R2_SEL=1, R3_SEL=0; named constants RF_SHIFT_ALL=4'b0000 and RF_LOAD_ALL=4'b1111; state enum {IDLE, RUN}.
- One natural sub-module: rf_seq_table (DEPTH x (4+CNT_W) write port, read port with ptr). The FSM and counters stay in the top module.

Test Plan:
- Reset check: rst for 2 cycles -> reg_file_inst=0000, busy=0, done=0, step_idx=0.
- Basic play: write e0={1111,rep0}, e1={0001,rep2}, e2={1000,rep1}; start with len=3 -> reg_file_inst = 1111, 0001 x3, 1000 x2 (6 cycles), then 0000 with a done pulse. Also drive a behavioural reg_file with R3_sel-loaded din_3 and check R0..R3 contents.
- len clamp / zero: len=9 with DEPTH=8 -> 8 entries played; len=0 -> done the next cycle, busy never asserted.
- Abort: e0={0100,rep15}; start len=1, abort at RUN cycle 5 -> next cycle 0000, busy=0, done=1, total busy=5 cycles.
- Cfg in RUN and restart: cfg_we at addr 1 during RUN -> cfg_err pulse, and a read-back replay shows the old value; start asserted during RUN is ignored; rst at RUN cycle 2 -> outputs reset, no done pulse.
